// File: rtl/ctrl_pkg.sv
// Shared definitions for the microcode sequencer: control bits, opcodes, state encoding.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
// Ports: none. Imported by ctrl_rom and ctrl_seq.
package ctrl_pkg;

  // Base control word: bit positions of the datapath strobes.
  localparam int CW_BASE_W = 16;
  typedef logic [CW_BASE_W-1:0] cw_t;

  localparam cw_t CB_HLT       = 16'h8000;  // halt the clock
  localparam cw_t CB_AI        = 16'h4000;  // A register in
  localparam cw_t CB_AO        = 16'h2000;  // A register out
  localparam cw_t CB_BI        = 16'h1000;  // B register in
  localparam cw_t CB_MI        = 16'h0800;  // memory address in
  localparam cw_t CB_RR        = 16'h0400;  // RAM read
  localparam cw_t CB_RW        = 16'h0200;  // RAM write
  localparam cw_t CB_II        = 16'h0100;  // instruction register in
  localparam cw_t CB_IO        = 16'h0080;  // instruction register (operand) out
  localparam cw_t CB_CI        = 16'h0040;  // program counter load
  localparam cw_t CB_CO        = 16'h0020;  // program counter out
  localparam cw_t CB_CE        = 16'h0010;  // program counter increment
  localparam cw_t CB_ALUOPTION = 16'h0008;  // ALU subtract select
  localparam cw_t CB_ALUO      = 16'h0004;  // ALU result out
  localparam cw_t CB_DI        = 16'h0002;  // display in
  localparam cw_t CB_FL        = 16'h0001;  // flags register in

  // Fetch microcode, shared by every instruction.
  localparam cw_t CW_FETCH0 = CB_CO | CB_MI;
  localparam cw_t CW_FETCH1 = CB_RR | CB_II | CB_CE;

  // Opcodes (low four bits of the latched opcode).
  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_LDA      = 4'h1;
  localparam logic [3:0] OP_LDB      = 4'h2;
  localparam logic [3:0] OP_PLUSTOA  = 4'h3;
  localparam logic [3:0] OP_PLUSTOB  = 4'h4;
  localparam logic [3:0] OP_SUBTOA   = 4'h5;
  localparam logic [3:0] OP_SUBTOB   = 4'h6;
  localparam logic [3:0] OP_ATORAM   = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_ATODIS   = 4'h9;
  localparam logic [3:0] OP_POWEROFF = 4'hA;
  localparam logic [3:0] OP_JC       = 4'hB;
  localparam logic [3:0] OP_JZ       = 4'hC;

  // Instruction length bounds: two fetch steps plus at most two exec steps.
  localparam int FETCH_LEN     = 2;
  localparam int MAX_EXEC_LEN  = 2;
  localparam int MAX_INSTR_LEN = FETCH_LEN + MAX_EXEC_LEN;

  // Number of exec steps for an opcode. Anything not listed (NOP, undecoded,
  // conditional jumps) is a single step.
  function automatic int unsigned exec_len(input logic [3:0] op);
    case (op)
      OP_LDA, OP_LDB, OP_ATORAM: exec_len = 2;
      default:                   exec_len = 1;
    endcase
  endfunction

  // Sequencer state; names the word currently presented on ctrl_wrd.
  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/ctrl_rom.sv
// Exec microcode table: (opcode, exec index, flags) -> (control word, last-step flag).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a looked-up word is consumed.
// Ports: opcode (OP_W), idx (exec step index, STEP_W), flag_c/flag_z -> word (16b), last.
// Config: `CTRL_SEQ_COND_JUMP_EN adds JC/JZ; otherwise they decode as NOP and flags are ignored.
module ctrl_rom
  import ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int STEP_W = 3
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [STEP_W-1:0] idx,
  input  logic              flag_c,
  input  logic              flag_z,
  output cw_t               word,
  output logic              last
);

  logic [3:0]  op;
  int unsigned len;

  always_comb begin
    // Any set bit above the 4-bit table makes the opcode undecoded -> NOP.
    op   = ((opcode >> 4) == '0) ? opcode[3:0] : OP_NOP;
    len  = exec_len(op);
    last = (idx == STEP_W'(len - 1));
    word = '0;
    case (op)
      OP_LDA:      word = (idx == '0) ? (CB_IO | CB_MI) : (CB_RR | CB_AI);
      OP_LDB:      word = (idx == '0) ? (CB_IO | CB_MI) : (CB_RR | CB_BI);
      OP_PLUSTOA:  word = CB_ALUO | CB_AI | CB_FL;
      OP_PLUSTOB:  word = CB_ALUO | CB_BI | CB_FL;
      OP_SUBTOA:   word = CB_ALUOPTION | CB_ALUO | CB_AI | CB_FL;
      OP_SUBTOB:   word = CB_ALUOPTION | CB_ALUO | CB_BI | CB_FL;
      OP_ATORAM:   word = (idx == '0) ? (CB_IO | CB_MI) : (CB_AO | CB_RW);
      OP_JUMP:     word = CB_IO | CB_CI;
      OP_ATODIS:   word = CB_AO | CB_DI;
      OP_POWEROFF: word = CB_HLT;
`ifdef CTRL_SEQ_COND_JUMP_EN
      OP_JC:       word = flag_c ? (CB_IO | CB_CI) : '0;
      OP_JZ:       word = flag_z ? (CB_IO | CB_CI) : '0;
`endif
      default:     word = '0;
    endcase
  end

`ifndef CTRL_SEQ_COND_JUMP_EN
  // Flags only matter to the conditional jumps.
  logic unused_flags;
  assign unused_flags = flag_c ^ flag_z;
`endif

endmodule

// File: rtl/ctrl_seq.sv
// Microcode sequencer: 2-step fetch then a per-opcode exec phase, driving the datapath control word.
// Latency: every output is registered; one control word per run=1 cycle, no dead cycle between instructions.
// Backpressure: run=0 stalls (word forced to 0, position held); HALT is sticky until RST.
// Ports: CLK, RST (sync, active-high), command (OP_W), run, flag_c, flag_z ->
//        ctrl_wrd (CW_W), step (STEP_W), instr_done, halted.
// Config: `CTRL_SEQ_COND_JUMP_EN enables JC (1011) / JZ (1100); flags sampled when the opcode is latched.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int CW_W   = 16,
  parameter int STEP_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [OP_W-1:0]   command,
  input  logic              run,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [CW_W-1:0]   ctrl_wrd,
  output logic [STEP_W-1:0] step,
  output logic              instr_done,
  output logic              halted
);

  // Elaboration-time guards on the parameter set.
  if (OP_W < 4) begin : g_chk_op_w
    $error("ctrl_seq: OP_W must be at least 4");
  end
  if (CW_W < CW_BASE_W) begin : g_chk_cw_w
    $error("ctrl_seq: CW_W must be at least 16");
  end
  if (MAX_INSTR_LEN > (1 << STEP_W)) begin : g_chk_step_w
    $error("ctrl_seq: STEP_W too small for the longest instruction");
  end

  state_t            state;
  logic [OP_W-1:0]   opcode_q;
  logic              flag_c_q;
  logic              flag_z_q;
  // Remembers that the emitted word was the final exec step; unlike
  // instr_done it survives a stall so the resume edge goes to fetch.
  logic              last_q;

  logic [OP_W-1:0]   rom_op;
  logic [STEP_W-1:0] rom_idx;
  logic              rom_fc;
  logic              rom_fz;
  cw_t               rom_word;
  logic              rom_last;
  logic              rom_hlt;

  // On the FETCH1 edge the ROM looks at the live opcode/flags (the ones being
  // latched); during EXEC it looks up the next step of the latched opcode.
  // Exec index of the next word is step - FETCH_LEN + 1.
  always_comb begin
    if (state == ST_FETCH1) begin
      rom_op  = command;
      rom_idx = '0;
      rom_fc  = flag_c;
      rom_fz  = flag_z;
    end else begin
      rom_op  = opcode_q;
      rom_idx = step - STEP_W'(FETCH_LEN - 1);
      rom_fc  = flag_c_q;
      rom_fz  = flag_z_q;
    end
  end

  ctrl_rom #(
    .OP_W   (OP_W),
    .STEP_W (STEP_W)
  ) u_rom (
    .opcode (rom_op),
    .idx    (rom_idx),
    .flag_c (rom_fc),
    .flag_z (rom_fz),
    .word   (rom_word),
    .last   (rom_last)
  );

  assign rom_hlt = (rom_word & CB_HLT) != '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_BOOT;
      ctrl_wrd   <= '0;
      step       <= '0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
      opcode_q   <= '0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      last_q     <= 1'b0;
    end else if (state == ST_HALT) begin
      // Sticky: everything holds until reset.
    end else if (!run) begin
      // Stall: blank the word, keep position so the next run edge resumes.
      ctrl_wrd   <= '0;
      instr_done <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state      <= ST_FETCH0;
          ctrl_wrd   <= CW_W'(CW_FETCH0);
          step       <= '0;
          instr_done <= 1'b0;
          last_q     <= 1'b0;
        end
        ST_FETCH0: begin
          state      <= ST_FETCH1;
          ctrl_wrd   <= CW_W'(CW_FETCH1);
          step       <= STEP_W'(1);
          instr_done <= 1'b0;
          last_q     <= 1'b0;
        end
        ST_FETCH1, ST_EXEC: begin
          if (state == ST_EXEC && last_q) begin
            // Instruction finished: go straight into the next fetch.
            state      <= ST_FETCH0;
            ctrl_wrd   <= CW_W'(CW_FETCH0);
            step       <= '0;
            instr_done <= 1'b0;
            last_q     <= 1'b0;
          end else begin
            if (state == ST_FETCH1) begin
              opcode_q <= command;
              flag_c_q <= flag_c;
              flag_z_q <= flag_z;
              step     <= STEP_W'(FETCH_LEN);
            end else begin
              step     <= step + STEP_W'(1);
            end
            ctrl_wrd   <= CW_W'(rom_word);
            instr_done <= rom_last;
            last_q     <= rom_last;
            halted     <= rom_hlt;
            state      <= rom_hlt ? ST_HALT : ST_EXEC;
          end
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Testbench for ctrl_seq: cycle-by-cycle scoreboard of expected (word, step, done, halted).
// Latency: each stimulus cycle pushes the expected post-edge outputs; they are popped and compared 1 time unit after the edge.
// Backpressure: run is driven per cycle to exercise stalls and the sticky halt.
module tb_ctrl_seq;

  logic        CLK;
  logic        RST;
  logic [3:0]  command;
  logic        run;
  logic        flag_c;
  logic        flag_z;
  logic [15:0] ctrl_wrd;
  logic [2:0]  step;
  logic        instr_done;
  logic        halted;

  ctrl_seq #(
    .OP_W   (4),
    .CW_W   (16),
    .STEP_W (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .command    (command),
    .run        (run),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .ctrl_wrd   (ctrl_wrd),
    .step       (step),
    .instr_done (instr_done),
    .halted     (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] wrd;
    logic [2:0]  stp;
    logic        done;
    logic        hlt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_n    = 0;

`ifdef CTRL_SEQ_COND_JUMP_EN
  localparam logic [15:0] JMP_TAKEN = 16'h00C0;
`else
  localparam logic [15:0] JMP_TAKEN = 16'h0000;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc_n, got, expv);
  endtask

  // Drive one cycle of stimulus, queue what must appear after the edge, then
  // pop and compare once the DUT has updated.
  task automatic cyc(input logic rst, input logic r, input logic [3:0] cmd,
                     input logic [15:0] ew, input logic [2:0] es,
                     input logic ed, input logic eh);
    exp_t e;
    RST     = rst;
    run     = r;
    command = cmd;
    exp_q.push_back('{wrd: ew, stp: es, done: ed, hlt: eh});
    @(posedge CLK);
    #1;
    cyc_n++;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("ctrl_wrd",   32'(ctrl_wrd),   32'(e.wrd));
      chk("step",       32'(step),       32'(e.stp));
      chk("instr_done", 32'(instr_done), 32'(e.done));
      chk("halted",     32'(halted),     32'(e.hlt));
    end
  endtask

  initial begin
    RST = 1'b1; run = 1'b1; command = 4'h1; flag_c = 1'b0; flag_z = 1'b0;

    // Reset held two cycles: everything zero.
    cyc(1, 1, 4'h1, 16'h0000, 3'd0, 0, 0);
    cyc(1, 1, 4'h1, 16'h0000, 3'd0, 0, 0);

    // LDA from boot, then straight into the next fetch.
    cyc(0, 1, 4'h1, 16'h0820, 3'd0, 0, 0);
    cyc(0, 1, 4'h1, 16'h0510, 3'd1, 0, 0);
    cyc(0, 1, 4'h1, 16'h0880, 3'd2, 0, 0);
    cyc(0, 1, 4'h1, 16'h4400, 3'd3, 1, 0);
    cyc(0, 1, 4'h1, 16'h0820, 3'd0, 0, 0);

    // PLUSTOA: single exec step; command change during exec is ignored.
    cyc(0, 1, 4'h3, 16'h0510, 3'd1, 0, 0);
    cyc(0, 1, 4'h3, 16'h4005, 3'd2, 1, 0);
    cyc(0, 1, 4'h7, 16'h0820, 3'd0, 0, 0);

    // ATORAM with a 3-cycle stall after exec step 0.
    cyc(0, 1, 4'h7, 16'h0510, 3'd1, 0, 0);
    cyc(0, 1, 4'h7, 16'h0880, 3'd2, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'h3, 16'h0000, 3'd2, 0, 0);
    cyc(0, 1, 4'h3, 16'h2200, 3'd3, 1, 0);
    cyc(0, 1, 4'h3, 16'h0820, 3'd0, 0, 0);

    // Conditional jumps (taken only when the feature is built in).
    cyc(0, 1, 4'hC, 16'h0510, 3'd1, 0, 0);
    flag_z = 1'b1;
    cyc(0, 1, 4'hC, JMP_TAKEN, 3'd2, 1, 0);
    flag_z = 1'b0;
    cyc(0, 1, 4'h0, 16'h0820, 3'd0, 0, 0);
    cyc(0, 1, 4'h0, 16'h0510, 3'd1, 0, 0);
    cyc(0, 1, 4'hC, 16'h0000, 3'd2, 1, 0);
    cyc(0, 1, 4'h0, 16'h0820, 3'd0, 0, 0);
    cyc(0, 1, 4'h0, 16'h0510, 3'd1, 0, 0);
    flag_c = 1'b1;
    cyc(0, 1, 4'hB, JMP_TAKEN, 3'd2, 1, 0);
    flag_c = 1'b0;
    cyc(0, 1, 4'h0, 16'h0820, 3'd0, 0, 0);
    cyc(0, 1, 4'h0, 16'h0510, 3'd1, 0, 0);
    cyc(0, 1, 4'hB, 16'h0000, 3'd2, 1, 0);

    // JUMP, ATODIS, undecoded opcode.
    cyc(0, 1, 4'h0, 16'h0820, 3'd0, 0, 0);
    cyc(0, 1, 4'h0, 16'h0510, 3'd1, 0, 0);
    cyc(0, 1, 4'h8, 16'h00C0, 3'd2, 1, 0);
    cyc(0, 1, 4'h0, 16'h0820, 3'd0, 0, 0);
    cyc(0, 1, 4'h0, 16'h0510, 3'd1, 0, 0);
    cyc(0, 1, 4'h9, 16'h2002, 3'd2, 1, 0);
    cyc(0, 1, 4'h0, 16'h0820, 3'd0, 0, 0);
    cyc(0, 1, 4'h0, 16'h0510, 3'd1, 0, 0);
    cyc(0, 1, 4'hF, 16'h0000, 3'd2, 1, 0);

    // Reset in the middle of LDA at step 3.
    cyc(0, 1, 4'h1, 16'h0820, 3'd0, 0, 0);
    cyc(0, 1, 4'h1, 16'h0510, 3'd1, 0, 0);
    cyc(0, 1, 4'h1, 16'h0880, 3'd2, 0, 0);
    cyc(0, 1, 4'h1, 16'h4400, 3'd3, 1, 0);
    cyc(1, 1, 4'h1, 16'h0000, 3'd0, 0, 0);
    cyc(0, 1, 4'h1, 16'h0820, 3'd0, 0, 0);

    // POWEROFF: sticky halt regardless of run, cleared only by reset.
    cyc(0, 1, 4'hA, 16'h0510, 3'd1, 0, 0);
    cyc(0, 1, 4'hA, 16'h8000, 3'd2, 1, 1);
    for (int i = 0; i < 10; i++) cyc(0, logic'(i[0]), 4'h1, 16'h8000, 3'd2, 1, 1);
    cyc(1, 1, 4'h1, 16'h0000, 3'd0, 0, 0);
    cyc(0, 1, 4'h1, 16'h0820, 3'd0, 0, 0);

    // Stall straight out of boot does not skip the first fetch.
    cyc(1, 1, 4'h1, 16'h0000, 3'd0, 0, 0);
    cyc(0, 0, 4'h1, 16'h0000, 3'd0, 0, 0);
    cyc(0, 1, 4'h1, 16'h0820, 3'd0, 0, 0);

    if (exp_q.size() != 0) chk("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
